// File: rtl/tile_pkg.sv
// Shared types for the tile_solver search cell: grid sizing, one-hot value/index
// widths and the controller state encoding.
package tile_pkg;

  localparam int unsigned GRID_ORDER = 3;
  localparam int unsigned LEN        = GRID_ORDER * GRID_ORDER;

  typedef logic [LEN-1:0] value_t;
  typedef logic [LEN:0]   index_t;

  typedef enum logic [2:0] {
    RESETIN,
    WAITING,
    INCRIDX,
    RQBIAS,
    LDBIAS,
    PASSFWD,
    PASSBAK,
    GIVEN
  } state_e;

endpackage

// File: rtl/tile_index_ring.sv
// One-hot candidate pointer of LEN+1 bits; the top bit means "empty, before
// candidate 0". Load-empty has priority over rotate; otherwise the ring holds.
module tile_index_ring #(
  parameter int unsigned LEN = 9
) (
  input  logic         clock_i,
  input  logic         load_empty_i,
  input  logic         rotate_i,
  output logic [LEN:0] index_o
);

  logic [LEN:0] index_q, index_d;

  always_comb begin
    index_d = index_q;
    if (load_empty_i) begin
      index_d = {1'b1, {LEN{1'b0}}};
    end else if (rotate_i) begin
      index_d = {index_q[LEN-1:0], index_q[LEN]};
    end
  end

  always_ff @(posedge clock_i) begin
    index_q <= index_d;
  end

  assign index_o = index_q;

endmodule

// File: rtl/tile_solver.sv
// Backtracking search cell for one grid tile: walks its candidate ring against a
// 1-cycle bias memory. Fixed-clue preload is enabled by defining TILE_GIVEN_EN.
module tile_solver #(
  parameter  int unsigned GRID_ORDER = 3,
  localparam int unsigned LEN        = GRID_ORDER * GRID_ORDER
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           myturn,
  input  logic           dir_bak,
  output logic           passfwd,
  output logic           passbak,
  output logic           busy,
  output logic [LEN-1:0] index_pass,
  output logic           rq_bias,
  input  logic [LEN-1:0] bias_value,
  input  logic [LEN-1:0] occup_mask,
  output logic [LEN-1:0] value_pass,
  input  logic           given_load,
  input  logic [LEN-1:0] given_value
);

  import tile_pkg::*;

  state_e         state_q, state_d;
  logic [LEN-1:0] value_q, value_d;
  logic [LEN:0]   index;
  logic           ring_load, ring_rot;
  logic           unused_bits;

`ifdef TILE_GIVEN_EN
  logic given_q, given_d;
  assign unused_bits = index[LEN];
`else
  assign unused_bits = ^{index[LEN], given_load, given_value, dir_bak};
`endif

  tile_index_ring #(.LEN(LEN)) u_ring (
    .clock_i     (clock),
    .load_empty_i(ring_load),
    .rotate_i    (ring_rot),
    .index_o     (index)
  );

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    ring_load = reset;
    ring_rot  = 1'b0;
`ifdef TILE_GIVEN_EN
    given_d   = given_q;
`endif
    unique case (state_q)
      RESETIN: state_d = WAITING;
      WAITING: begin
`ifdef TILE_GIVEN_EN
        if (given_load) begin
          state_d   = GIVEN;
          value_d   = given_value;
          given_d   = 1'b1;
          ring_load = 1'b1;
        end else
`endif
        if (myturn) state_d = INCRIDX;
      end
      // The ring advances here even on exhaustion, so it comes to rest at the empty bit.
      INCRIDX: begin
        ring_rot = 1'b1;
        if (index[LEN-1]) begin
          state_d = PASSBAK;
          value_d = '0;
        end else begin
          state_d = RQBIAS;
        end
      end
      RQBIAS: state_d = LDBIAS;
      LDBIAS: begin
        if ((bias_value & occup_mask) != '0) begin
          state_d = INCRIDX;
        end else begin
          state_d = PASSFWD;
          value_d = bias_value;
        end
      end
      PASSFWD, PASSBAK: begin
`ifdef TILE_GIVEN_EN
        state_d = given_q ? GIVEN : WAITING;
`else
        state_d = WAITING;
`endif
      end
      GIVEN: begin
`ifdef TILE_GIVEN_EN
        if (myturn) state_d = dir_bak ? PASSBAK : PASSFWD;
`else
        state_d = WAITING;
`endif
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESETIN;
      value_q <= '0;
`ifdef TILE_GIVEN_EN
      given_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
`ifdef TILE_GIVEN_EN
      given_q <= given_d;
`endif
    end
  end

  assign passfwd    = (state_q == PASSFWD);
  assign passbak    = (state_q == PASSBAK);
  assign rq_bias    = (state_q == RQBIAS);
  assign busy       = (state_q == INCRIDX) || (state_q == RQBIAS) || (state_q == LDBIAS);
  assign index_pass = index[LEN-1:0];
  assign value_pass = value_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && state_q == LDBIAS) begin
      assert ($onehot(bias_value))
        else $error("tile_solver: bias_value %h is not one-hot", bias_value);
    end
  end
`endif

endmodule

// File: tb/tb_tile_solver.sv
// Randomized scoreboard bench for tile_solver; the model walks candidates per turn.
module tb_tile_solver;
  import tile_pkg::*;

  logic   clock = 1'b0, reset = 1'b1, myturn = 1'b0, dir_bak = 1'b0, given_load = 1'b0;
  value_t given_value = '0, bias_value = value_t'(1), occup_mask = '0;
  logic   passfwd, passbak, busy, rq_bias;
  value_t index_pass, value_pass;

  always #5 clock = ~clock;

  tile_solver #(.GRID_ORDER(GRID_ORDER)) dut (
    .clock(clock), .reset(reset), .myturn(myturn), .dir_bak(dir_bak),
    .passfwd(passfwd), .passbak(passbak), .busy(busy), .index_pass(index_pass),
    .rq_bias(rq_bias), .bias_value(bias_value), .occup_mask(occup_mask),
    .value_pass(value_pass), .given_load(given_load), .given_value(given_value)
  );

  typedef enum int {EV_RQ = 0, EV_FWD = 1, EV_BAK = 2} kind_e;
  typedef struct {
    kind_e       kind;
    int unsigned cyc;
    value_t      idx;
    value_t      val;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0, errors = 0;
  value_t      bias_tab [LEN];
  int unsigned m_pos = LEN;
  value_t      m_val = '0;
  bit          m_given = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void push_ev(kind_e k, int unsigned c, value_t i, value_t v);
    ev_t e;
    e.kind = k; e.cyc = c; e.idx = i; e.val = v;
    exp_q.push_back(e);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT pulses a strobe.
  initial begin
    ev_t   ev;
    kind_e ak;
    forever begin
      @(posedge clock); #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missed_event: required kind %0d at cycle %0d, actual no pulse", ev.kind, ev.cyc);
      end
      if (rq_bias || passfwd || passbak) begin
        check("pulse_exclusive", 32'(passfwd & passbak), 32'd0);
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: cycle %0d actual rq=%0b fwd=%0b bak=%0b, required none",
                   cyc, rq_bias, passfwd, passbak);
        end else begin
          ev = exp_q.pop_front();
          ak = rq_bias ? EV_RQ : (passfwd ? EV_FWD : EV_BAK);
          check("event_kind", 32'(ak), 32'(ev.kind));
          check("event_index_pass", 32'(index_pass), 32'(ev.idx));
          check("event_value_pass", 32'(value_pass), 32'(ev.val));
          check("event_busy", 32'(busy), 32'(ev.kind == EV_RQ));
        end
      end
    end
  end

  // Bias memory: answers a read strobe on the following cycle.
  initial begin
    forever begin
      @(posedge clock); #2;
      if (rq_bias) begin
        for (int i = 0; i < int'(LEN); i++) begin
          if (index_pass[i]) bias_value = bias_tab[i];
        end
      end
    end
  end

  function automatic value_t rand_onehot();
    return value_t'(1) << $urandom_range(LEN - 1, 0);
  endfunction

  task automatic check_outputs_zero(input string name);
    check(name, 32'({passfwd, passbak, busy, rq_bias, index_pass, value_pass}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_outputs_zero("reset_outputs");
    reset   = 1'b0;
    m_pos   = LEN;
    m_val   = '0;
    m_given = 1'b0;
    @(negedge clock);
  endtask

  // One grant of control; the model tries candidates from the one after m_pos.
  task automatic do_turn(input bit bak);
    int unsigned base, n, start, lat;
    value_t      prev;
    bit          ok;
    @(negedge clock);
    base    = cyc;
    myturn  = 1'b1;
    dir_bak = bak;
    prev    = m_val;
    lat     = 1;
    if (m_given) begin
      push_ev(bak ? EV_BAK : EV_FWD, base + 1, '0, m_val);
    end else begin
      start = (m_pos == LEN) ? 0 : m_pos + 1;
      n  = 0;
      ok = 1'b0;
      for (int unsigned k = start; k < LEN && !ok; k++) begin
        push_ev(EV_RQ, base + 2 + 3 * n, value_t'(1) << k, prev);
        if ((bias_tab[k] & occup_mask) == '0) begin
          ok    = 1'b1;
          m_pos = k;
          m_val = bias_tab[k];
          lat   = 4 + 3 * n;
          push_ev(EV_FWD, base + lat, value_t'(1) << k, m_val);
        end
        n++;
      end
      if (!ok) begin
        m_pos = LEN;
        m_val = '0;
        lat   = 2 + 3 * n;
        push_ev(EV_BAK, base + lat, '0, '0);
      end
    end
    @(negedge clock);
    myturn = 1'b0;
    repeat (lat) @(negedge clock);
  endtask

  initial begin
    int unsigned base;
    for (int i = 0; i < int'(LEN); i++) bias_tab[i] = value_t'(1);
    repeat (3) @(negedge clock);
    check_outputs_zero("initial_reset");
    reset = 1'b0;
    @(negedge clock);

    // First-try success.
    for (int i = 0; i < int'(LEN); i++) bias_tab[i] = 9'h004;
    occup_mask = '0;
    do_turn(1'b0);

    // Two rejections then success at candidate 2.
    do_reset();
    bias_tab[0] = 9'h001; bias_tab[1] = 9'h002; bias_tab[2] = 9'h008;
    occup_mask  = 9'h003;
    do_turn(1'b0);

    // Commit at candidate 3, then backtrack resumes at candidate 4.
    do_reset();
    bias_tab[0] = 9'h001; bias_tab[1] = 9'h002; bias_tab[2] = 9'h001; bias_tab[3] = 9'h004;
    bias_tab[4] = 9'h010;
    do_turn(1'b0);
    do_turn(1'b1);

    // Exhaustion from empty, then restart at candidate 0.
    do_reset();
    occup_mask = '1;
    do_turn(1'b0);
    occup_mask = '0;
    do_turn(1'b0);

    // Reset while in LDBIAS of a fresh search.
    do_reset();
    @(negedge clock);
    base   = cyc;
    myturn = 1'b1;
    push_ev(EV_RQ, base + 2, value_t'(1), m_val);
    @(negedge clock);
    myturn = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_outputs_zero("reset_mid_search");
    reset = 1'b0;
    m_pos = LEN;
    m_val = '0;
    @(negedge clock);

`ifndef TILE_GIVEN_EN
    // Clue preload is inert in this build.
    do_turn(1'b0);
    @(negedge clock);
    given_load  = 1'b1;
    given_value = 9'h100;
    @(negedge clock);
    given_load  = 1'b0;
    @(negedge clock);
    check("given_ignored_value", 32'(value_pass), 32'(m_val));
    do_turn(1'b1);
`endif

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < int'(LEN); i++) bias_tab[i] = rand_onehot();
      occup_mask = ($urandom_range(5, 0) == 0) ? '1 : value_t'($urandom & $urandom);
      if ($urandom_range(14, 0) == 0) do_reset();
      do_turn(1'($urandom_range(1, 0)));
    end

`ifdef TILE_GIVEN_EN
    do_reset();
    @(negedge clock);
    given_load  = 1'b1;
    given_value = 9'h100;
    @(negedge clock);
    given_load  = 1'b0;
    m_given     = 1'b1;
    m_val       = 9'h100;
    m_pos       = LEN;
    do_turn(1'b0);
    do_turn(1'b1);
    do_turn(1'b0);
    @(negedge clock);
    check("given_value_held", 32'(value_pass), 32'h100);
    do_reset();
`endif

    repeat (10) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
